id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline register for the 5-stage RV32I core, with built-in load-use hazard detection and branch flush handling. It captures decoded operands and control from the ID stage and presents the E-stage fields (Rs1E, Rs2E, RdE, RegWriteE, …) consumed by the forwarding unit and the ALU. It also drives StallF/StallD/FlushD back to the front end and keeps saturating stall and flush event counters for debug.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of event counters
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PCD, PCPlus4D, RD1D, RD2D, ImmExtD  in  XLEN each  decode-stage values
- Rs1D, Rs2D, RdD  in  5 each  register indices from decode
- RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD  in  1 each  control
- ResultSrcD  in  2  00 ALU, 01 load, 10 PC+4
- ALUControlD  in  3  ALU operation
- PCSrcE  in  1  branch/jump taken, resolved in E this cycle
- PCE, PCPlus4E, RD1E, RD2E, ImmExtE  out  XLEN each  registered copies
- Rs1E, Rs2E, RdE  out  5 each  to forwarding unit
- RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  out  1 each
- ResultSrcE  out  2;  ALUControlE  out  3
- StallF, StallD, FlushD  out  1 each  front-end hazard controls (combinational)
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- lwstall = (ResultSrcE == 01) && (RdE != 0) && ((Rs1D == RdE) || (Rs2D == RdE)).
- StallF = StallD = lwstall; FlushD = PCSrcE.
- FlushE = lwstall || PCSrcE. If FlushE: register loads a bubble, else loads all D inputs.
- Bubble: every control bit 0, ResultSrcE = 00, ALUControlE = 000, Rs1E = Rs2E = RdE = 0, all XLEN fields 0.
- Simultaneous lwstall and PCSrcE: StallF/StallD and FlushD all assert; E gets a bubble. The front end applies flush priority over stall on the D register; this block needs no extra handling.
- stall_cnt increments by 1 each cycle lwstall = 1. flush_cnt increments by 1 each cycle PCSrcE = 1. Both saturate at 2^CNT_W−1 and never wrap.
- Rs1D/Rs2D = 0 never triggers a stall, because RdE != 0 is required.

## Timing
- Reset (rst_n low, asynchronous): all E outputs go to bubble values and both counters go to 0. StallF, StallD and FlushD follow from RdE = 0 and PCSrcE, so they are 0 while PCSrcE = 0.
- Deassertion is synchronous to clk. The first capture happens on the first rising edge with rst_n high.
- Latency: D inputs appear on E outputs 1 cycle later.
- Hazard outputs are combinational from current E state and D inputs, valid in the same cycle.
- A load-use stall produces exactly one bubble. On the next cycle ResultSrcE = 00, lwstall drops, and the held D instruction enters E.
- Reset mid-stall clears E to a bubble immediately. No pending stall survives reset.

## Structure
- Shared package core_pkg holds:
  - RESULT_ALU, RESULT_LOAD and RESULT_PC4 encodings
  - ALUControl encodings
  - XLEN default
  - a packed struct id_ex_ctrl_t holding the control bundle, so the bubble is a single constant (CTRL_BUBBLE)
- One sub-module is natural: load_use_detect, which is combinational and produces lwstall from ResultSrcE, RdE, Rs1D and Rs2D.
- Counters live in the top module as a shared saturating-increment function.

## Test plan
- Reset: hold rst_n = 0 mid-stream with RegWriteE = 1, RdE = 5 → all E outputs 0 asynchronously and both counters 0. First edge after release captures D.
- Normal pass: D = {PC 0x100, RdD 3, RegWriteD 1, ALUControlD 010} → next cycle PCE = 0x100, RdE = 3, RegWriteE = 1, no stall.
- Load-use: lw x5 in E (ResultSrcE 01, RdE 5), add with Rs1D = 5 in D → StallF = StallD = 1 that cycle, E bubble next cycle, add in E the following cycle, stall_cnt = 1.
- Load to x0: ResultSrcE 01, RdE 0, Rs1D 0 → no stall, stall_cnt unchanged.
- Branch flush: PCSrcE = 1 with a valid D instruction → FlushD = 1, E bubble next cycle, flush_cnt = 1. Repeat with lwstall also true → bubble, flush_cnt and stall_cnt each +1.
- Saturation: with CNT_W = 4, force 20 consecutive PCSrcE cycles → flush_cnt holds at 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: result-select and ALU encodings,
// and the ID/EX control bundle with its bubble constant.
package core_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [1:0] RESULT_ALU  = 2'b00;
   localparam logic [1:0] RESULT_LOAD = 2'b01;
   localparam logic [1:0] RESULT_PC4  = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic [1:0] result_src;
      logic [2:0] alu_control;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } id_ex_idx_t;

   localparam id_ex_ctrl_t CTRL_BUBBLE = id_ex_ctrl_t'('0);
   localparam id_ex_idx_t  IDX_BUBBLE  = id_ex_idx_t'('0);

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bundle: decode-side fields in, E-side fields and
// front-end hazard controls out.
interface id_ex_stage_if #(
   parameter int XLEN = 32
) ();

   logic [XLEN-1:0] PCD, PCPlus4D, RD1D, RD2D, ImmExtD;
   logic [4:0]      Rs1D, Rs2D, RdD;
   logic            RegWriteD, MemWriteD, ALUSrcD;
   logic            BranchD, JumpD;
   logic [1:0]      ResultSrcD;
   logic [2:0]      ALUControlD;
   logic            PCSrcE;

   logic [XLEN-1:0] PCE, PCPlus4E, RD1E, RD2E, ImmExtE;
   logic [4:0]      Rs1E, Rs2E, RdE;
   logic            RegWriteE, MemWriteE, ALUSrcE;
   logic            BranchE, JumpE;
   logic [1:0]      ResultSrcE;
   logic [2:0]      ALUControlE;
   logic            StallF, StallD, FlushD;

   modport master (
      output PCD, PCPlus4D, RD1D, RD2D, ImmExtD,
      output Rs1D, Rs2D, RdD,
      output RegWriteD, MemWriteD, ALUSrcD,
      output BranchD, JumpD, ResultSrcD, ALUControlD,
      output PCSrcE,
      input  PCE, PCPlus4E, RD1E, RD2E, ImmExtE,
      input  Rs1E, Rs2E, RdE,
      input  RegWriteE, MemWriteE, ALUSrcE,
      input  BranchE, JumpE, ResultSrcE, ALUControlE,
      input  StallF, StallD, FlushD
   );

   modport slave (
      input  PCD, PCPlus4D, RD1D, RD2D, ImmExtD,
      input  Rs1D, Rs2D, RdD,
      input  RegWriteD, MemWriteD, ALUSrcD,
      input  BranchD, JumpD, ResultSrcD, ALUControlD,
      input  PCSrcE,
      output PCE, PCPlus4E, RD1E, RD2E, ImmExtE,
      output Rs1E, Rs2E, RdE,
      output RegWriteE, MemWriteE, ALUSrcE,
      output BranchE, JumpE, ResultSrcE, ALUControlE,
      output StallF, StallD, FlushD
   );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard: a load in E whose rd feeds a source of the
// instruction in D. x0 is never a real dependency.
module load_use_detect
   import core_pkg::*;
(
   input  logic [1:0] result_src_e,
   input  logic [4:0] rd_e,
   input  logic [4:0] rs1_d,
   input  logic [4:0] rs2_d,
   output logic       lwstall
);

   logic is_load;
   logic rd_live;
   logic src_hit;

   always_comb begin
      is_load = (result_src_e == RESULT_LOAD);
      rd_live = (rd_e != 5'd0);
      src_hit = (rs1_d == rd_e) || (rs2_d == rd_e);
      lwstall = is_load && rd_live && src_hit;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and
// saturating debug counters for both events.
module id_ex_stage
   import core_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ex_stage_if.slave     bus,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   id_ex_ctrl_t     ctrl_in, ctrl_d, ctrl_q;
   id_ex_idx_t      idx_in, idx_d, idx_q;
   logic [XLEN-1:0] pc_d, pc_q, pc4_d, pc4_q;
   logic [XLEN-1:0] rd1_d, rd1_q, rd2_d, rd2_q;
   logic [XLEN-1:0] imm_d, imm_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
   logic            lwstall;
   logic            flush_e;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v,
      input logic             en
   );
      if (en && (v != {CNT_W{1'b1}}))
         return v + 1'b1;
      return v;
   endfunction

   assign ctrl_in = '{
      reg_write:   bus.RegWriteD,
      mem_write:   bus.MemWriteD,
      alu_src:     bus.ALUSrcD,
      branch:      bus.BranchD,
      jump:        bus.JumpD,
      result_src:  bus.ResultSrcD,
      alu_control: bus.ALUControlD
   };

   assign idx_in = '{
      rs1: bus.Rs1D,
      rs2: bus.Rs2D,
      rd:  bus.RdD
   };

   load_use_detect u_lud (
      .result_src_e (ctrl_q.result_src),
      .rd_e         (idx_q.rd),
      .rs1_d        (bus.Rs1D),
      .rs2_d        (bus.Rs2D),
      .lwstall      (lwstall)
   );

   // Either hazard turns the E slot into a bubble this edge
   assign flush_e = lwstall | bus.PCSrcE;

   always_comb begin
      ctrl_d = CTRL_BUBBLE;
      idx_d  = IDX_BUBBLE;
      pc_d   = '0;
      pc4_d  = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      if (!flush_e) begin
         ctrl_d = ctrl_in;
         idx_d  = idx_in;
         pc_d   = bus.PCD;
         pc4_d  = bus.PCPlus4D;
         rd1_d  = bus.RD1D;
         rd2_d  = bus.RD2D;
         imm_d  = bus.ImmExtD;
      end
      stall_cnt_d = sat_inc(stall_cnt_q, lwstall);
      flush_cnt_d = sat_inc(flush_cnt_q, bus.PCSrcE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q      <= CTRL_BUBBLE;
         idx_q       <= IDX_BUBBLE;
         pc_q        <= '0;
         pc4_q       <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         imm_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         idx_q       <= idx_d;
         pc_q        <= pc_d;
         pc4_q       <= pc4_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         imm_q       <= imm_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.PCE         = pc_q;
   assign bus.PCPlus4E    = pc4_q;
   assign bus.RD1E        = rd1_q;
   assign bus.RD2E        = rd2_q;
   assign bus.ImmExtE     = imm_q;
   assign bus.Rs1E        = idx_q.rs1;
   assign bus.Rs2E        = idx_q.rs2;
   assign bus.RdE         = idx_q.rd;
   assign bus.RegWriteE   = ctrl_q.reg_write;
   assign bus.MemWriteE   = ctrl_q.mem_write;
   assign bus.ALUSrcE     = ctrl_q.alu_src;
   assign bus.BranchE     = ctrl_q.branch;
   assign bus.JumpE       = ctrl_q.jump;
   assign bus.ResultSrcE  = ctrl_q.result_src;
   assign bus.ALUControlE = ctrl_q.alu_control;

   assign bus.StallF = lwstall;
   assign bus.StallD = lwstall;
   assign bus.FlushD = bus.PCSrcE;

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
